// File: rtl/oled_pkg.sv
// ---------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the 96x64 RGB565 OLED pipeline: panel geometry,
// common RGB565 colours used by the screen renderers, the column/row window
// command opcodes, the streamer state enum and a helper that yields the
// window-setup command sequence byte by byte.
// ---------------------------------------------------------------------------
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  // RGB565 colours: rrrrr_gggggg_bbbbb
  localparam logic [15:0] BLACK    = 16'h0000;
  localparam logic [15:0] WHITE    = 16'hFFFF;
  localparam logic [15:0] RED      = 16'hF800;
  localparam logic [15:0] GREEN    = 16'h07E0;
  localparam logic [15:0] BLUE     = 16'h001F;
  localparam logic [15:0] NAVYBLUE = 16'h0010;
  localparam logic [15:0] YELLOW   = 16'hFFE0;
  localparam logic [15:0] ORANGE   = 16'hFC00;
  localparam logic [15:0] GREY     = 16'h8410;

  // Panel window commands, each followed by start and end address bytes.
  localparam logic [7:0] CMD_SET_COLUMN = 8'h15;
  localparam logic [7:0] CMD_SET_ROW    = 8'h75;
  localparam int         WINDOW_CMD_BYTES = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_FETCH,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Byte idx of the sequence: 15 00 <last_col> 75 00 <last_row>.
  function automatic logic [7:0] window_cmd(input logic [2:0] idx,
                                            input logic [7:0] last_col,
                                            input logic [7:0] last_row);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD_SET_COLUMN;
      3'd1:    b = 8'h00;
      3'd2:    b = last_col;
      3'd3:    b = CMD_SET_ROW;
      3'd4:    b = 8'h00;
      default: b = last_row;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// ---------------------------------------------------------------------------
// oled_spi_shifter
// Mode-0 SPI transmitter. A start pulse loads a 16-bit word and a bit count;
// bits leave MSB first from data[15]. Each bit spends CLKDIV cycles with
// sclk low then CLKDIV cycles with sclk high; mosi only changes on the edge
// where sclk goes (or already is) low. done is high during the cycle whose
// closing edge is the final falling edge, so the owner can issue the next
// start on that very edge and words go out back to back with no gap.
//
// Ports:
//   clock, reset_n  system clock, asynchronous active-low reset
//   start           load data/bit_count and begin shifting (wins over done)
//   data            word to send, MSB first
//   bit_count       number of bits to send from the top of data (1..16)
//   done            final falling sclk edge happens at the end of this cycle
//   sclk, mosi      SPI clock (idles low) and data
// ---------------------------------------------------------------------------
module oled_spi_shifter #(
  parameter int CLKDIV = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] data,
  input  logic [4:0]  bit_count,
  output logic        done,
  output logic        sclk,
  output logic        mosi
);

  localparam int               DIV_W    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

  logic [15:0]      shift_q;
  logic [4:0]       bits_left;
  logic [DIV_W-1:0] div_cnt;
  logic             active;
  logic             phase_end;

  assign phase_end = active && (div_cnt == DIV_LAST);
  assign done      = phase_end && sclk && (bits_left == 5'd1);

  // NOTE: every register here uses <= so all of them sample pre-edge values;
  // blocking assignments would make mosi/shift_q ordering depend on code order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bits_left <= '0;
      div_cnt   <= '0;
      active    <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else if (start) begin
      // First bit is presented immediately, with sclk low.
      shift_q   <= {data[14:0], 1'b0};
      mosi      <= data[15];
      bits_left <= bit_count;
      div_cnt   <= '0;
      sclk      <= 1'b0;
      active    <= 1'b1;
    end else if (active) begin
      if (phase_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          if (bits_left == 5'd1) begin
            active <= 1'b0;
            mosi   <= 1'b0;
          end else begin
            mosi      <= shift_q[15];
            shift_q   <= {shift_q[14:0], 1'b0};
            bits_left <= bits_left - 5'd1;
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/oled_pixel_streamer.sv
// ---------------------------------------------------------------------------
// oled_pixel_streamer
// Scans the panel in raster order, presents (x, y) to the renderer mux,
// captures the returned RGB565 word LAT+1 cycles after x/y settle, and
// streams it MSB first over a write-only mode-0 SPI link. cs_n is held low
// for the whole frame; frame_done pulses for one cycle when the last bit of
// the bottom-right pixel has gone out.
//
// Build option: define OLED_STREAM_WINDOW_EN to prefix every frame with the
// 6-byte column/row window command (dc=0). Without it pixel data follows
// cs_n immediately and the window is left to the power-up init sequence.
//
// Ports:
//   clock, reset_n   system clock, asynchronous active-low reset
//   enable           level; frames run back to back while high
//   x, y             pixel coordinate requested from the renderers
//   pixel_data       RGB565 colour for the current x/y (LAT cycles later)
//   busy             high from frame start until frame_done
//   frame_done       one-cycle pulse at end of frame
//   spi_sclk/mosi    SPI clock and data (mode 0, MSB first)
//   spi_cs_n         chip select, low for the whole frame
//   spi_dc           0 = command byte, 1 = pixel data
// ---------------------------------------------------------------------------
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int WIDTH  = OLED_WIDTH,
  parameter int HEIGHT = OLED_HEIGHT,
  parameter int CLKDIV = 4,
  parameter int LAT    = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic [6:0]  x,
  output logic [6:0]  y,
  input  logic [15:0] pixel_data,
  output logic        busy,
  output logic        frame_done,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        spi_dc
);

  localparam int               LAT_W    = $clog2(LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT);
  localparam logic [6:0]       X_LAST   = 7'(WIDTH - 1);
  localparam logic [6:0]       Y_LAST   = 7'(HEIGHT - 1);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;

  logic             shift_start;
  logic             shift_done;
  logic [15:0]      shift_word;
  logic [4:0]       shift_bits;

`ifdef OLED_STREAM_WINDOW_EN
  localparam logic [2:0] CMD_LAST = 3'(WINDOW_CMD_BYTES - 1);
  localparam logic [7:0] COL_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] ROW_LAST = 8'(HEIGHT - 1);
  logic [2:0] cmd_idx;
`endif

  // Shifter load requests. Command bytes ride in the top byte so the
  // shifter always sends from bit 15; the next byte is loaded on the same
  // edge the previous one finishes, keeping the sequence gap-free.
  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    shift_start = 1'b0;
    shift_word  = pixel_data;
    shift_bits  = 5'd16;
    case (state)
`ifdef OLED_STREAM_WINDOW_EN
      ST_IDLE: begin
        if (enable) begin
          shift_start = 1'b1;
          shift_word  = {window_cmd(3'd0, COL_LAST, ROW_LAST), 8'h00};
          shift_bits  = 5'd8;
        end
      end
      ST_CMD: begin
        if (shift_done && (cmd_idx != CMD_LAST)) begin
          shift_start = 1'b1;
          shift_word  = {window_cmd(cmd_idx + 3'd1, COL_LAST, ROW_LAST), 8'h00};
          shift_bits  = 5'd8;
        end
      end
`endif
      // Capture edge: pixel_data has been valid since LAT cycles after x/y.
      ST_FETCH: shift_start = (lat_cnt == LAT_LAST);
      default:  ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      x          <= '0;
      y          <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_dc     <= 1'b1;
`ifdef OLED_STREAM_WINDOW_EN
      cmd_idx    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            x        <= '0;
            y        <= '0;
            lat_cnt  <= '0;
`ifdef OLED_STREAM_WINDOW_EN
            spi_dc   <= 1'b0;
            cmd_idx  <= '0;
            state    <= ST_CMD;
`else
            state    <= ST_FETCH;
`endif
          end
        end
`ifdef OLED_STREAM_WINDOW_EN
        ST_CMD: begin
          if (shift_done) begin
            if (cmd_idx == CMD_LAST) begin
              spi_dc  <= 1'b1;
              lat_cnt <= '0;
              state   <= ST_FETCH;
            end else begin
              cmd_idx <= cmd_idx + 3'd1;
            end
          end
        end
`endif
        ST_FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            spi_dc <= 1'b1;
            state  <= ST_SHIFT;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (shift_done) begin
            lat_cnt <= '0;
            if (x < X_LAST) begin
              x     <= x + 7'd1;
              state <= ST_FETCH;
            end else if (y < Y_LAST) begin
              x     <= '0;
              y     <= y + 7'd1;
              state <= ST_FETCH;
            end else begin
              x          <= '0;
              y          <= '0;
              busy       <= 1'b0;
              spi_cs_n   <= 1'b1;
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        // Single cycle with cs_n high before IDLE can start the next frame.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  oled_spi_shifter #(
    .CLKDIV(CLKDIV)
  ) u_shifter (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (shift_start),
    .data     (shift_word),
    .bit_count(shift_bits),
    .done     (shift_done),
    .sclk     (spi_sclk),
    .mosi     (spi_mosi)
  );

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// ---------------------------------------------------------------------------
// tb_oled_pixel_streamer
// Bench for oled_pixel_streamer on a reduced 8x4 panel (CLKDIV=2, LAT=1).
// A registered renderer returns {2'b0, y, x} XOR a random per-frame key and
// drives random junk while sclk is high. An SPI monitor rebuilds words from
// the wire; expected words, coordinates and timing come from frame
// arithmetic. Also honours OLED_STREAM_WINDOW_EN when the RTL is built so.
// ---------------------------------------------------------------------------
module tb_oled_pixel_streamer;

  localparam int TB_W      = 8;
  localparam int TB_H      = 4;
  localparam int TB_CLKDIV = 2;
  localparam int TB_LAT    = 1;
  localparam int NPIX      = TB_W * TB_H;
  localparam int PIX_CYC   = TB_LAT + 1 + 32 * TB_CLKDIV;
`ifdef OLED_STREAM_WINDOW_EN
  localparam int CMD_CYC   = 96 * TB_CLKDIV;
`else
  localparam int CMD_CYC   = 0;
`endif
  localparam int FRAME_LOW = NPIX * PIX_CYC + CMD_CYC;
  localparam int BUDGET    = FRAME_LOW + 200;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [6:0]  x;
  logic [6:0]  y;
  logic [15:0] pixel_data;
  logic        busy;
  logic        frame_done;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        spi_dc;

  oled_pixel_streamer #(
    .WIDTH (TB_W),
    .HEIGHT(TB_H),
    .CLKDIV(TB_CLKDIV),
    .LAT   (TB_LAT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .x         (x),
    .y         (y),
    .pixel_data(pixel_data),
    .busy      (busy),
    .frame_done(frame_done),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_dc    (spi_dc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- renderer model ----------------
  logic [15:0] key;
  logic [15:0] rend_q;
  logic [15:0] junk;

  always @(posedge clock) rend_q <= {2'b00, y, x} ^ key;
  always @(negedge clock) junk = 16'($urandom);
  assign pixel_data = spi_sclk ? junk : rend_q;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input int idx, input logic [15:0] k);
    int px;
    int py;
    px = idx % TB_W;
    py = idx / TB_W;
    return {2'b00, 7'(py), 7'(px)} ^ k;
  endfunction

  // ---------------- SPI monitor ----------------
  typedef struct {
    logic [15:0] word;
    logic [6:0]  x;
    logic [6:0]  y;
    logic        dc_bad;
  } rx_t;

  rx_t        pix_q[$];
  logic [7:0] cmd_q[$];

  logic        sclk_prev     = 1'b0;
  logic        busy_prev     = 1'b0;
  int          bit_n         = 0;
  logic [15:0] acc           = '0;
  logic        word_dc       = 1'b1;
  logic        word_dc_bad   = 1'b0;
  logic [6:0]  wx            = '0;
  logic [6:0]  wy            = '0;
  int          pix_cnt       = 0;
  int          low_len       = 0;
  int          last_low_len  = 0;
  int          hi_len        = 0;
  int          last_gap      = 0;
  bit          seen_low      = 0;
  bit          pix_seen      = 0;
  int          first_pix_lat = 0;
  int          fd_cur        = 0;
  int          last_fd_width = 0;
  bit          fd_busy_ok    = 0;

  always @(negedge clock) begin
    if (spi_cs_n) begin
      bit_n    = 0;
      pix_seen = 0;
      if (low_len > 0) begin
        last_low_len = low_len;
        low_len      = 0;
      end
      if (seen_low) hi_len++;
    end else begin
      if (hi_len > 0) begin
        last_gap = hi_len;
        hi_len   = 0;
      end
      seen_low = 1;
      low_len++;
      if (spi_sclk && !sclk_prev) begin
        if (bit_n == 0) begin
          wx          = x;
          wy          = y;
          word_dc     = spi_dc;
          word_dc_bad = 1'b0;
          if (spi_dc && !pix_seen) begin
            pix_seen      = 1;
            first_pix_lat = low_len - 1;
          end
        end else if (spi_dc !== word_dc) begin
          word_dc_bad = 1'b1;
        end
        acc = {acc[14:0], spi_mosi};
        bit_n++;
        if (word_dc && bit_n == 16) begin
          pix_q.push_back('{acc, wx, wy, word_dc_bad});
          pix_cnt++;
          bit_n = 0;
        end else if (!word_dc && bit_n == 8) begin
          cmd_q.push_back(acc[7:0]);
          bit_n = 0;
        end
      end
    end
    if (frame_done) begin
      fd_cur++;
      if (fd_cur == 1) fd_busy_ok = !busy && busy_prev;
    end else if (fd_cur > 0) begin
      last_fd_width = fd_cur;
      fd_cur        = 0;
    end
    busy_prev = busy;
    sclk_prev = spi_sclk;
  end

  // ---------------- helpers ----------------
  task automatic check_idle_outputs();
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_dc", spi_dc, 1);
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic verify_frame(input logic [15:0] k);
    rx_t r;
`ifdef OLED_STREAM_WINDOW_EN
    logic [7:0] exp_cmd [6];
    exp_cmd[0] = 8'h15;
    exp_cmd[1] = 8'h00;
    exp_cmd[2] = 8'(TB_W - 1);
    exp_cmd[3] = 8'h75;
    exp_cmd[4] = 8'h00;
    exp_cmd[5] = 8'(TB_H - 1);
    check("cmd_count", cmd_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (cmd_q.size() > 0) check("cmd_byte", cmd_q.pop_front(), exp_cmd[i]);
    end
`else
    check("cmd_count", cmd_q.size(), 0);
`endif
    check("word_count", pix_q.size(), NPIX);
    for (int i = 0; i < NPIX; i++) begin
      if (pix_q.size() > 0) begin
        r = pix_q.pop_front();
        check("pix_word", r.word, model_word(i, k));
        check("pix_xy", {r.y, r.x}, {7'(i / TB_W), 7'(i % TB_W)});
        check("pix_dc_stable", r.dc_bad, 0);
      end
    end
    cmd_q.delete();
    pix_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int base;
    int drop;
    int rb;
    int idle_busy;

    reset_n = 1'b0;
    enable  = 1'b0;
    key     = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs();
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Single frame from a one-cycle enable pulse.
    key = 16'($urandom);
    pulse_enable();
    wait_fd();
    check("busy_at_done", busy, 0);
    verify_frame(key);
    repeat (4) @(negedge clock);
    check("frame_low_cycles", last_low_len, FRAME_LOW);
    check("first_pixel_latency", first_pix_lat, TB_LAT + 1 + TB_CLKDIV + CMD_CYC);
    check("done_width", last_fd_width, 1);
    check("busy_falls_with_done", fd_busy_ok, 1);
    check("idle_busy", busy, 0);
    check("idle_cs_n", spi_cs_n, 1);

    // Two frames with enable held high.
    key    = 16'($urandom);
    enable = 1'b1;
    wait_fd();
    check("done_xy", {y, x}, 0);
    verify_frame(key);
    n = 0;
    while (spi_cs_n !== 1'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("cs_gap_cycles", last_gap, 2);
    check("restart_xy", {y, x}, 0);
    enable = 1'b0;
    wait_fd();
    verify_frame(key);
    repeat (4) @(negedge clock);
    check("frame2_low_cycles", last_low_len, FRAME_LOW);

    // Enable dropped mid-frame: frame completes, nothing follows.
    key    = 16'($urandom);
    drop   = $urandom_range(5, NPIX - 6);
    base   = pix_cnt;
    enable = 1'b1;
    n = 0;
    while ((pix_cnt - base) < drop && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    enable = 1'b0;
    wait_fd();
    verify_frame(key);
    idle_busy = 0;
    repeat (3 * PIX_CYC) begin
      @(negedge clock);
      if (busy || !spi_cs_n) idle_busy++;
    end
    check("stays_idle", idle_busy, 0);
    check("no_extra_words", pix_q.size(), 0);

    // Asynchronous reset in the middle of pixel 5's word.
    key  = 16'($urandom);
    rb   = $urandom_range(2, 12);
    base = pix_cnt;
    pulse_enable();
    n = 0;
    while (((pix_cnt - base) < 5 || bit_n < rb) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    check("reached_pixel5", pix_cnt - base, 5);
    check("busy_mid_shift", busy, 1);
    #2 reset_n = 1'b0;
    #1 check_idle_outputs();
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    pix_q.delete();
    cmd_q.delete();
    repeat (2) @(negedge clock);
    key = 16'($urandom);
    pulse_enable();
    wait_fd();
    verify_frame(key);
    repeat (4) @(negedge clock);
    check("post_reset_latency", first_pix_lat, TB_LAT + 1 + TB_CLKDIV + CMD_CYC);
    check("post_reset_low_cycles", last_low_len, FRAME_LOW);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
